// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches, buffers returned
// instructions with their PCs, and flushes everything on a redirect from EX.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instrF,
    output logic [ADDR_W-1:0]  pcF,
    output logic [ADDR_W-1:0]  pcplus4F
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  fpc;
    logic [ADDR_W-1:0]  pcq [DEPTH];
    logic [PTR_W-1:0]   pcqHead;
    logic [PTR_W-1:0]   pcqTail;
    logic [ADDR_W-1:0]  fifoPc [DEPTH];
    logic [INSTR_W-1:0] fifoInstr [DEPTH];
    logic [PTR_W-1:0]   fifoHead;
    logic [PTR_W-1:0]   fifoTail;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   outst;
    logic [CNT_W-1:0]   drop;

    logic [CNT_W:0]     inUse;
    logic               reqFire;
    logic               rspFire;
    logic               fifoPush;
    logic               fifoPop;
    logic [CNT_W-1:0]   dropAfter;
    logic [CNT_W-1:0]   outstNext;

    // Outstanding requests plus buffered entries may never exceed DEPTH, so
    // every accepted request is guaranteed a FIFO slot when it returns.
    always_comb begin
        inUse          = {1'b0, outst} + {1'b0, cnt};
        imem_req_valid = reset && !redirect && (inUse < (CNT_W+1)'(DEPTH));
        imem_req_addr  = fpc;
        reqFire        = imem_req_valid && imem_req_ready;
        rspFire        = imem_rsp_valid && (outst != '0);
        fifoPush       = rspFire && (drop == '0) && !redirect;
        fifoPop        = instr_valid && instr_ready && !redirect;
        dropAfter      = (rspFire && (drop != '0)) ? drop - CNT_W'(1) : drop;
        outstNext      = outst + CNT_W'(reqFire) - CNT_W'(rspFire);
    end

    always_comb begin
        instr_valid = (cnt != '0);
        instrF      = '0;
        pcF         = '0;
        pcplus4F    = '0;
        if (instr_valid) begin
            instrF   = fifoInstr[fifoHead];
            pcF      = fifoPc[fifoHead];
            pcplus4F = fifoPc[fifoHead] + ADDR_W'(4);
        end
    end

    // On redirect every request still in flight becomes a response to drop;
    // the in-flight PC queue keeps draining so it stays aligned with memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            pcqHead  <= '0;
            pcqTail  <= '0;
            fifoHead <= '0;
            fifoTail <= '0;
            cnt      <= '0;
            outst    <= '0;
            drop     <= '0;
        end else begin
            outst <= outstNext;
            if (reqFire) pcqTail <= pcqTail + PTR_W'(1);
            if (rspFire) pcqHead <= pcqHead + PTR_W'(1);
            if (redirect) begin
                fpc      <= redirect_pc & ~ADDR_W'(3);
                fifoHead <= '0;
                fifoTail <= '0;
                cnt      <= '0;
                drop     <= outstNext;
            end else begin
                if (reqFire)  fpc      <= fpc + ADDR_W'(4);
                if (fifoPush) fifoTail <= fifoTail + PTR_W'(1);
                if (fifoPop)  fifoHead <= fifoHead + PTR_W'(1);
                cnt  <= cnt + CNT_W'(fifoPush) - CNT_W'(fifoPop);
                drop <= dropAfter;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reqFire) pcq[pcqTail] <= fpc;
        if (fifoPush) begin
            fifoPc[fifoTail]    <= pcq[pcqHead];
            fifoInstr[fifoTail] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable memory model pushes the
// expected PC on every issued request and a monitor checks each FIFO head.
module tb_fetch_queue;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReqT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          memLat = 1;
    int          fireCnt = 0;
    logic [31:0] expFpc = '0;
    logic [31:0] expQ[$];
    memReqT      pend[$];

    fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instrF(instrF), .pcF(pcF), .pcplus4F(pcplus4F)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rq, input logic ir);
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = rq;
        instr_ready    = ir;
    endtask

    // Memory model runs just after each falling edge: it decides what the next
    // rising edge will see and books the expected PC of every accepted request.
    initial begin
        memReqT r;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                expQ.delete();
                expFpc = 32'h0;
            end else if (redirect) begin
                expQ.delete();
                expFpc = redirect_pc & ~32'h3;
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
                r = pend.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(r.addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("reqAddr", imem_req_addr, expFpc);
                r.addr = imem_req_addr;
                r.due  = cyc + 1 + memLat;
                pend.push_back(r);
                expQ.push_back(expFpc);
                expFpc = expFpc + 32'h4;
                fireCnt++;
            end
        end
    end

    // Monitor: any visible head must be the oldest expected fetch.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && instr_valid && !redirect) begin
                if (expQ.size() == 0) begin
                    checkOutput("staleHead", pcF, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("headPc", pcF, expQ[0]);
                    checkOutput("headInstr", instrF, memWord(expQ[0]));
                    checkOutput("headPc4", pcplus4F, expQ[0] + 32'h4);
                    if (instr_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #3;
        checkOutput("rstInstrValid", 32'(instr_valid), 32'h0);
        checkOutput("rstReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("rstReqAddr", imem_req_addr, 32'h0);
        checkOutput("rstInstrF", instrF, 32'h0);
        checkOutput("rstPcF", pcF, 32'h0);
        checkOutput("rstPc4F", pcplus4F, 32'h0);
    endtask

    task automatic waitHead(input string tag, input logic [31:0] pc);
        int n = 0;
        do begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            #3;
            n++;
        end while (!instr_valid && n < 20);
        if (!instr_valid) begin
            checkOutput({tag, "Timeout"}, 32'h0, 32'h1);
        end else begin
            checkOutput({tag, "Pc"}, pcF, pc);
            checkOutput({tag, "Instr"}, instrF, memWord(pc));
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #3;
            n++;
        end while ((instr_valid || imem_rsp_valid || pend.size() != 0) && n < 60);
        if (n >= 60) checkOutput("drainTimeout", 32'h0, 32'h1);
        else         checkOutput("leftover", 32'(expQ.size()), 32'h0);
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming at full rate with a 1-cycle memory.
        resetDut();
        memLat = 1;
        @(negedge clk); reset = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); #3;
        checkOutput("fillEmpty", 32'(instr_valid), 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); #3;
            checkOutput("streamValid", 32'(instr_valid), 32'h1);
            checkOutput("streamPc", pcF, 32'(4 * k));
            checkOutput("streamPc4", pcplus4F, 32'(4 * k + 4));
        end
        drain();

        // Stalled downstream: capacity stops issue at four.
        resetDut();
        memLat = 1;
        @(negedge clk); reset = 1'b1; fireCnt = 0; applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) begin @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); end
        #3;
        checkOutput("fullReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("fullInstrValid", 32'(instr_valid), 32'h1);
        checkOutput("fullHeadPc", pcF, 32'h0);
        checkOutput("fullFires", 32'(fireCnt), 32'h4);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); #3;
        checkOutput("resumeValid", 32'(imem_req_valid), 32'h1);
        checkOutput("resumeAddr", imem_req_addr, 32'h10);
        drain();

        // Redirect with two slow responses in flight.
        resetDut();
        memLat = 3;
        @(negedge clk); reset = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk); applyStimulus(1'b1, 32'h103, 1'b1, 1'b1); #3;
        checkOutput("redirReqValid", 32'(imem_req_valid), 32'h0);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); #3;
        checkOutput("redirNextValid", 32'(imem_req_valid), 32'h1);
        checkOutput("redirNextAddr", imem_req_addr, 32'h100);
        waitHead("redirHead", 32'h100);
        drain();

        // Redirect colliding with a response and a pop while two are buffered.
        resetDut();
        memLat = 1;
        @(negedge clk); reset = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk); applyStimulus(1'b1, 32'h200, 1'b0, 1'b1); #3;
        checkOutput("collideReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("collidePreValid", 32'(instr_valid), 32'h1);
        checkOutput("collideRsp", 32'(imem_rsp_valid), 32'h1);
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); #3;
        checkOutput("collideFlushed", 32'(instr_valid), 32'h0);
        waitHead("collideHead", 32'h200);
        drain();

        // Memory back-pressure: address holds while ready is low.
        resetDut();
        memLat = 1;
        @(negedge clk); reset = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) begin @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b0, 1'b1); #3;
            checkOutput("stallValid", 32'(imem_req_valid), 32'h1);
            checkOutput("stallAddr", imem_req_addr, 32'hC);
        end
        @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        drain();

        // Asynchronous reset mid-stream with three requests in flight.
        resetDut();
        memLat = 3;
        @(negedge clk); reset = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) begin @(negedge clk); applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); end
        #3;
        checkOutput("preRstInstrValid", 32'(instr_valid), 32'h1);
        #1 reset = 1'b0;
        #1;
        checkOutput("asyncInstrValid", 32'(instr_valid), 32'h0);
        checkOutput("asyncReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("asyncPcF", pcF, 32'h0);
        repeat (4) @(negedge clk);
        reset = 1'b1; applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); #3;
        checkOutput("restartValid", 32'(imem_req_valid), 32'h1);
        checkOutput("restartAddr", imem_req_addr, 32'h0);
        waitHead("restartHead", 32'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
